// File: rtl/lite16_pkg.sv
// lite16_pkg: shared sequencer states, opcode class encodings and trap causes
package lite16_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEMA, WB, TRAP} state_t;
  typedef struct packed {logic ri, cmp, mem, ld, st, jmp, fn;} cls_t;
  localparam logic [3:0] OP_CMP = 4'b1000, OP_LD = 4'b1001, OP_ST = 4'b1010, OP_JMP = 4'b1011;
  localparam logic [1:0] TC_NONE = 2'b00, TC_ILL = 2'b01, TC_FETCH = 2'b10, TC_DATA = 2'b11;
endpackage

// File: rtl/opcode_decoder.sv
// opcode_decoder: combinational class decode of the top four opcode bits
module opcode_decoder import lite16_pkg::*; (
  input  logic [3:0] top,
  output cls_t       cls,
  output logic       ill
);
  always_comb begin
    cls = '0;
    cls.fn = !top[3];
    cls.ri = !top[3] && top[2];
    cls.cmp = top == OP_CMP;
    cls.ld = top == OP_LD;
    cls.st = top == OP_ST;
    cls.mem = (top == OP_LD) || (top == OP_ST);
    cls.jmp = top == OP_JMP;
  end
  assign ill = top[3] && top[2];
endmodule

// File: rtl/seq_control_unit.sv
// seq_control_unit: multi-cycle fetch/decode/execute sequencer with memory timeout traps
module seq_control_unit import lite16_pkg::*; #(
  parameter int OPW = 4,
  parameter int TMO = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [OPW-1:0]   codeop,
  input  logic             mem_ready,
  input  logic             trap_clr,
  output logic             ri,
  output logic             cmp,
  output logic             mem,
  output logic             ld,
  output logic             st,
  output logic             jmp,
  output logic             fn,
  output logic [OPW-2:0]   fn_sel,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_jump,
  output logic             reg_we,
  output logic             flags_we,
  output logic             busy,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired
);
  localparam int WW = $clog2(TMO);
  state_t state, state_nx;
  cls_t dec, cls;
  logic dec_ill, tmo, ret;
  logic [WW-1:0] wcnt;
  opcode_decoder u_dec (.top(codeop[OPW-1:OPW-4]), .cls(dec), .ill(dec_ill));
  // mem_ready in the last allowed cycle still completes the access
  assign tmo = !mem_ready && wcnt == WW'(TMO - 1);
  assign ret = state == EXEC || state == WB || (state == MEMA && cls.st && mem_ready);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cls <= '0;
      fn_sel <= '0;
      wcnt <= '0;
      trap_cause <= TC_NONE;
      retired <= '0;
    end else begin
      state <= state_nx;
      wcnt <= state_nx != state ? '0 : (state == FETCH || state == MEMA) && !mem_ready ? wcnt + WW'(1) : wcnt;
      if (state == DECODE) begin
        cls <= dec;
        fn_sel <= codeop[OPW-2:0];
      end else if (state_nx == FETCH || state_nx == IDLE) begin
        cls <= '0;
        fn_sel <= '0;
      end
      if (state_nx == TRAP && state != TRAP)
        trap_cause <= state == DECODE ? TC_ILL : state == FETCH ? TC_FETCH : TC_DATA;
      else if (state == TRAP && trap_clr)
        trap_cause <= TC_NONE;
      retired <= retired + CNT_W'(ret);
    end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = run ? FETCH : IDLE;
      FETCH:   state_nx = mem_ready ? DECODE : tmo ? TRAP : FETCH;
      DECODE:  state_nx = dec_ill ? TRAP : dec.mem ? MEMA : EXEC;
      EXEC:    state_nx = run ? FETCH : IDLE;
      MEMA:    state_nx = mem_ready ? (cls.ld ? WB : run ? FETCH : IDLE) : tmo ? TRAP : MEMA;
      WB:      state_nx = run ? FETCH : IDLE;
      TRAP:    state_nx = trap_clr ? IDLE : TRAP;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    {ri, cmp, mem, ld, st, jmp, fn} = cls;
    mem_req = state == FETCH || state == MEMA;
    mem_we = state == MEMA && cls.st;
    ir_we = state == FETCH && mem_ready;
    pc_we = ret;
    pc_jump = state == EXEC && cls.jmp;
    reg_we = (state == EXEC && cls.fn) || state == WB;
    flags_we = state == EXEC && cls.cmp;
    busy = state != IDLE && state != TRAP;
    trap = state == TRAP;
  end
endmodule

// File: tb/tb_seq_control_unit.sv
// tb_seq_control_unit: randomized instruction streams checked cycle by cycle against a transaction-level model
module tb_seq_control_unit;
  localparam int TMO = 4;
  localparam logic [8:0] S_MREQ = 9'h100, S_MWE = 9'h080, S_IRWE = 9'h040, S_PCWE = 9'h020,
                         S_PCJ = 9'h010, S_REGWE = 9'h008, S_FLWE = 9'h004, S_BUSY = 9'h002, S_TRAP = 9'h001;
  logic clk = 0, rst_n = 0, run = 0, mem_ready = 0, trap_clr = 0;
  logic [3:0] codeop = 0;
  logic ri, cmp, mem, ld, st, jmp, fn, mem_req, mem_we, ir_we, pc_we, pc_jump, reg_we, flags_we, busy, trap;
  logic [2:0] fn_sel, retired;
  logic [1:0] trap_cause, seen_cause;
  logic [6:0] m_fl = 0;
  logic [2:0] m_sel = 0;
  logic [1:0] m_cause = 0;
  int m_ret = 0, checks = 0, errors = 0;
  seq_control_unit #(.OPW(4), .TMO(TMO), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .codeop(codeop), .mem_ready(mem_ready), .trap_clr(trap_clr),
    .ri(ri), .cmp(cmp), .mem(mem), .ld(ld), .st(st), .jmp(jmp), .fn(fn), .fn_sel(fn_sel),
    .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we), .pc_jump(pc_jump),
    .reg_we(reg_we), .flags_we(flags_we), .busy(busy), .trap(trap), .trap_cause(trap_cause), .retired(retired)
  );
  always #5 clk = ~clk;
  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction
  function automatic logic [3:0] r4();
    return 4'($urandom_range(0, 15));
  endfunction
  // {ri,cmp,mem,ld,st,jmp,fn} straight from the opcode class table
  function automatic logic [6:0] cls(input int op);
    return {op >= 4 && op < 8, op == 8, op == 9 || op == 10, op == 9, op == 10, op == 11, op < 8};
  endfunction
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask
  task automatic cmp_now(input string nm, input logic [8:0] s);
    chk(nm, {8'd0, ri, cmp, mem, ld, st, jmp, fn, fn_sel, mem_req, mem_we, ir_we, pc_we, pc_jump,
             reg_we, flags_we, busy, trap, trap_cause, retired},
        {8'd0, m_fl, m_sel, s, m_cause, 3'(m_ret)});
  endtask
  task automatic cyc(input string nm, input logic r, input logic rdy, input logic clr, input logic [3:0] op, input logic [8:0] s);
    @(negedge clk);
    run = r;
    mem_ready = rdy;
    trap_clr = clr;
    codeop = op;
    #1 cmp_now(nm, s);
  endtask
  task automatic idle_go();
    int n = $urandom_range(0, 2);
    for (int k = 0; k < n; k++) cyc("idle", 0, rb(), rb(), r4(), 0);
    cyc("idle_run", 1, rb(), rb(), r4(), 0);
  endtask
  task automatic trapseq();
    int n = $urandom_range(0, 2);
    for (int k = 0; k < n; k++) cyc("trap", rb(), rb(), 0, r4(), S_TRAP);
    cyc("trap_clr", rb(), rb(), 1, r4(), S_TRAP);
    seen_cause = trap_cause;
    m_cause = 0;
    m_fl = 0;
    m_sel = 0;
    idle_go();
  endtask
  task automatic retire(input logic rn);
    m_ret = (m_ret + 1) % 8;
    m_fl = 0;
    m_sel = 0;
    if (!rn) idle_go();
  endtask
  // one instruction starting in FETCH; wf/wm are wait cycles before mem_ready, >= TMO means timeout
  task automatic instr(input int op, input int wf, input int wm, input logic rn);
    logic [6:0] c = cls(op);
    for (int k = 0; k < wf && k < TMO; k++) cyc("fetch_wait", rb(), 0, rb(), r4(), S_MREQ | S_BUSY);
    if (wf >= TMO) begin
      m_cause = 2;
      trapseq();
      return;
    end
    cyc("fetch", rb(), 1, rb(), r4(), S_MREQ | S_IRWE | S_BUSY);
    cyc("decode", rb(), rb(), rb(), 4'(op), S_BUSY);
    m_fl = c;
    m_sel = 3'(op);
    if (op >= 12) begin
      m_cause = 1;
      trapseq();
    end else if (!c[4]) begin
      cyc("exec", rn, rb(), rb(), r4(), S_PCWE | S_BUSY | (c[0] ? S_REGWE : 9'h0) | (c[5] ? S_FLWE : 9'h0) | (c[1] ? S_PCJ : 9'h0));
      retire(rn);
    end else begin
      for (int k = 0; k < wm && k < TMO; k++) cyc("mema_wait", rb(), 0, rb(), r4(), S_MREQ | S_BUSY | (c[2] ? S_MWE : 9'h0));
      if (wm >= TMO) begin
        m_cause = 3;
        trapseq();
      end else if (c[2]) begin
        cyc("mema_st", rn, 1, rb(), r4(), S_MREQ | S_MWE | S_PCWE | S_BUSY);
        retire(rn);
      end else begin
        cyc("mema_ld", rb(), 1, rb(), r4(), S_MREQ | S_BUSY);
        cyc("wb", rn, rb(), rb(), r4(), S_REGWE | S_PCWE | S_BUSY);
        retire(rn);
      end
    end
  endtask
  function automatic int wpick();
    return $urandom_range(0, 9) < 7 ? $urandom_range(0, 2) : $urandom_range(0, TMO);
  endfunction
  initial begin
    @(negedge clk);
    @(negedge clk);
    #1 cmp_now("reset", 0);
    @(negedge clk);
    rst_n = 1;
    idle_go();
    instr(0, 0, 0, 0);
    chk("lit_ret_fn", 32'(retired), 1);
    instr(9, 0, 3, 0);
    chk("lit_ret_ld", 32'(retired), 2);
    instr(12, 0, 0, 0);
    chk("lit_cause_ill", 32'(seen_cause), 1);
    instr(0, TMO, 0, 0);
    chk("lit_cause_fetch", 32'(seen_cause), 2);
    instr(5, TMO - 1, 0, 0);
    chk("lit_ret_lastcyc", 32'(retired), 3);
    for (int i = 0; i < 9; i++) instr(11, 0, 0, i != 8);
    chk("lit_ret_wrap", 32'(retired), 4);
    instr(10, 1, TMO, 0);
    chk("lit_cause_data", 32'(seen_cause), 3);
    cyc("f_rst", rb(), 1, rb(), r4(), S_MREQ | S_IRWE | S_BUSY);
    cyc("d_rst", rb(), rb(), rb(), 4'd9, S_BUSY);
    m_fl = cls(9);
    m_sel = 3'd1;
    cyc("mema_rst", rb(), 0, rb(), r4(), S_MREQ | S_BUSY);
    @(negedge clk);
    mem_ready = 0;
    run = 0;
    #2 rst_n = 0;
    #1 m_fl = 0;
    m_sel = 0;
    m_ret = 0;
    m_cause = 0;
    cmp_now("rst_mid_mema", 0);
    chk("lit_rst_memreq", 32'(mem_req), 0);
    @(negedge clk);
    rst_n = 1;
    idle_go();
    for (int i = 0; i < 400; i++) instr($urandom_range(0, 15), wpick(), wpick(), $urandom_range(0, 3) != 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_control_unit.md
SEQ_CONTROL_UNIT -- requirements
Module: seq_control_unit

Interface
REQ-001 Parameter OPW, default 4: opcode width, SHALL be >= 4; class decode uses codeop[OPW-1:OPW-4].
REQ-002 Parameter TMO, default 16: memory wait timeout in cycles, SHALL be >= 2.
REQ-003 Parameter CNT_W, default 16: retired-instruction counter width.
REQ-004 Ports SHALL be as follows; one clock, reset asynchronous and active-low:
  clk  in  1  clock, all state on rising edge
  rst_n  in  1  asynchronous active-low reset
  run  in  1  permit new instruction fetch
  codeop  in  OPW  opcode from instruction bus, sampled in DECODE
  mem_ready  in  1  memory completes current access this cycle
  trap_clr  in  1  leave TRAP
  ri, cmp, mem, ld, st, jmp, fn  out  1 each  registered class flags of current instruction
  fn_sel  out  OPW-1  codeop[OPW-2:0] of latched instruction
  mem_req  out  1  memory access request
  mem_we  out  1  write strobe, only with mem_req
  ir_we  out  1  load instruction register
  pc_we  out  1  update PC
  pc_jump  out  1  select jump target for PC, only with pc_we
  reg_we  out  1  register file write
  flags_we  out  1  flag register write
  busy  out  1  state not IDLE and not TRAP
  trap  out  1  state is TRAP
  trap_cause  out  2  00 none, 01 illegal opcode, 10 fetch timeout, 11 data timeout
  retired  out  CNT_W  retired-instruction count

Function
REQ-005 Class map (top 4 bits): 0xxx fn (0x1xx also ri), 1000 cmp, 1001 ld (mem), 1010 st (mem), 1011 jmp, 11xx illegal.
REQ-006 States SHALL be IDLE, FETCH, DECODE, EXEC, MEMA, WB, TRAP.
REQ-007 IDLE: run=1 -> FETCH next cycle; otherwise stay.
REQ-008 FETCH: mem_req=1, mem_we=0; on mem_ready: ir_we=1 same cycle, -> DECODE.
REQ-009 DECODE: latch codeop and class flags; fn/cmp/jmp -> EXEC; ld/st -> MEMA; illegal -> TRAP, cause 01.
REQ-010 EXEC: one cycle; fn: reg_we=1; cmp: flags_we=1; jmp: pc_jump=1; all: pc_we=1, retire.
REQ-011 MEMA: mem_req=1, mem_we=st; on mem_ready: st -> pc_we=1, retire; ld -> WB.
REQ-012 WB: reg_we=1, pc_we=1, retire.
REQ-013 Retire: retired increments by 1, wraps from all-ones to 0; next state FETCH if run=1 else IDLE.
REQ-014 Wait counter SHALL clear on entry to FETCH/MEMA and count cycles without mem_ready; after TMO waiting cycles -> TRAP, cause 10 (FETCH) or 11 (MEMA).
REQ-015 mem_ready in the final timeout cycle SHALL win: access completes, no trap.
REQ-016 TRAP: all strobes 0, class flags held; trap_clr=1 -> IDLE, trap_cause cleared to 00.
REQ-017 Latency with immediate mem_ready: fn/cmp/jmp/st 3 cycles, ld 4 cycles, FETCH to FETCH.
REQ-018 Class flags SHALL be 0 in IDLE and FETCH; strobes are Moore outputs, 0 in any state not listed above.
REQ-019 run deasserting mid-instruction SHALL not abort it; only the next fetch is suppressed.

Reset
REQ-020 rst_n=0 SHALL immediately force IDLE, all outputs 0, retired=0, wait counter 0, trap_cause 00, including mid-access.

Structure
REQ-021 lite16_pkg SHALL hold state enum, class opcode constants, trap cause codes.
REQ-022 Combinational class decode SHALL be sub-module opcode_decoder, instantiated once.

Verification
REQ-023 run=1, codeop 0000, mem_ready=1 -> states FETCH,DECODE,EXEC; fn=1, reg_we, pc_we in EXEC; retired=1.
REQ-024 codeop 1001, mem_ready=0 for 3 MEMA cycles then 1 -> mem_req held 4 cycles, WB reg_we, retired+1.
REQ-025 codeop 1100 -> TRAP, trap_cause 01, busy 0; trap_clr -> IDLE.
REQ-026 TMO=4, mem_ready stuck 0 in FETCH -> TRAP after 4 cycles, cause 10; ready in cycle 4 -> DECODE instead.
REQ-027 CNT_W=3, 9 codeop 1011 instructions -> retired=1, pc_jump with pc_we each EXEC.
REQ-028 rst_n low during MEMA with mem_req=1 -> mem_req 0 asynchronously, IDLE, retired 0.
